// File: rtl/seq_trigger_mc.sv
// Sequencer-trigger stage: channel/SysEx filter, trigger + data_ready generation, patch echo FIFO.
// Optional echo FIFO is built when SEQ_TRIG_ECHO_EN is defined.
module seq_trigger_mc #(
  parameter int NUM_CH     = 16,
  parameter int ECHO_DEPTH = 4,
  parameter int DRDY_DLY   = 2
) (
  input  logic              reg_clk,
  input  logic              reset_reg_N,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic              byteready,
  input  logic [7:0]        midi_in_data,
  input  logic [7:0]        midibyte_nr,
  input  logic [3:0]        status_ch,
  input  logic              is_st_sysex,
  input  logic              syx_cmd,
  input  logic              patch_send,
  input  logic              auto_syx_cmd,
  input  logic              echo_rdy,
  output logic [3:0]        cur_midi_ch,
  output logic [7:0]        midi_bytes,
  output logic [7:0]        seq_databyte,
  output logic              seq_trigger,
  output logic              data_ready,
  output logic              is_data_byte,
  output logic              is_velocity,
  output logic              echo_valid,
  output logic [7:0]        echo_byte,
  output logic              echo_ovf
);

  logic [15:0]       mask_ext;
  logic              match;
  logic [3:0]        ch_q, ch_d;
  logic [7:0]        mb_q, mb_d, sd_q, sd_d;
  logic              trig_q, trig_d, drdy_q, drdy_d;
  logic [1:0]        syx_q, syx_d;
  logic [DRDY_DLY:0] dly_q, dly_d;
  logic              cmd_edge, trig_edge;

  // Channels at or above NUM_CH fail the range check, so the widened mask bits never matter.
  assign mask_ext  = 16'(ch_mask);
  assign match     = is_st_sysex | (({1'b0, status_ch} < 5'(NUM_CH)) & mask_ext[status_ch]);
  assign cmd_edge  = syx_q[0] & ~syx_q[1];
  assign trig_edge = dly_q[DRDY_DLY-1] & ~dly_q[DRDY_DLY];

  always_comb begin
    ch_d   = status_ch;
    mb_d   = match ? midibyte_nr : 8'h00;
    sd_d   = match ? midi_in_data : 8'h00;
    trig_d = match & byteready;
    syx_d  = {syx_q[0], syx_cmd};
    dly_d  = {dly_q[DRDY_DLY-1:0], trig_q};
    drdy_d = cmd_edge | ((patch_send | auto_syx_cmd) & trig_edge);
  end

  always_ff @(posedge reg_clk) begin
    if (!reset_reg_N) begin
      ch_q   <= '0;
      mb_q   <= '0;
      sd_q   <= '0;
      trig_q <= 1'b0;
      drdy_q <= 1'b0;
      syx_q  <= '0;
      dly_q  <= '0;
    end else begin
      ch_q   <= ch_d;
      mb_q   <= mb_d;
      sd_q   <= sd_d;
      trig_q <= trig_d;
      drdy_q <= drdy_d;
      syx_q  <= syx_d;
      dly_q  <= dly_d;
    end
  end

  assign cur_midi_ch  = ch_q;
  assign midi_bytes   = mb_q;
  assign seq_databyte = sd_q;
  assign seq_trigger  = trig_q;
  assign data_ready   = drdy_q;
  assign is_data_byte = mb_q[0];
  assign is_velocity  = !mb_q[0] && (mb_q != 8'h00);

`ifdef SEQ_TRIG_ECHO_EN
  localparam int AW = $clog2(ECHO_DEPTH);

  logic [ECHO_DEPTH-1:0][7:0] mem_q;
  logic [AW-1:0]              wr_q, rd_q;
  logic [AW:0]                cnt_q, cnt_d;
  logic                       ovf_q, full, empty, push, pop, wr_en;

  assign full  = (cnt_q == (AW+1)'(ECHO_DEPTH));
  assign empty = (cnt_q == '0);
  assign push  = patch_send & trig_q;
  assign pop   = !empty & echo_rdy;
  // A pop frees the slot this cycle, so a full FIFO still accepts a concurrent push.
  assign wr_en = push & (!full | pop);

  always_comb begin
    cnt_d = cnt_q;
    if (wr_en && !pop)      cnt_d = cnt_q + (AW+1)'(1);
    else if (!wr_en && pop) cnt_d = cnt_q - (AW+1)'(1);
  end

  always_ff @(posedge reg_clk) begin
    if (!reset_reg_N) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (wr_en) wr_q <= wr_q + AW'(1);
      if (pop)   rd_q <= rd_q + AW'(1);
      if (push && full && !pop) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge reg_clk) begin
    if (wr_en) mem_q[wr_q] <= sd_q;
  end

  assign echo_valid = !empty;
  assign echo_byte  = empty ? 8'h00 : mem_q[rd_q];
  assign echo_ovf   = ovf_q;
`else
  logic unused_echo;
  assign unused_echo = echo_rdy;
  assign echo_valid  = 1'b0;
  assign echo_byte   = 8'h00;
  assign echo_ovf    = 1'b0;
`endif

endmodule

// File: tb/tb_seq_trigger_mc.sv
// Self-checking bench for seq_trigger_mc: directed test-plan steps followed by random traffic,
// all outputs compared every cycle against a history/queue reference model.
module tb_seq_trigger_mc;
  localparam int NUM_CH = 4;
  localparam int DEPTH  = 4;
  localparam int DLY    = 2;
`ifdef SEQ_TRIG_ECHO_EN
  localparam bit ECHO = 1'b1;
`else
  localparam bit ECHO = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, byteready, is_st_sysex, syx_cmd, patch_send, auto_syx_cmd, echo_rdy;
  logic [NUM_CH-1:0] ch_mask;
  logic [7:0]        midi_in_data, midibyte_nr;
  logic [3:0]        status_ch;
  logic [3:0]        cur_midi_ch;
  logic [7:0]        midi_bytes, seq_databyte, echo_byte;
  logic              seq_trigger, data_ready, is_data_byte, is_velocity, echo_valid, echo_ovf;

  seq_trigger_mc #(.NUM_CH(NUM_CH), .ECHO_DEPTH(DEPTH), .DRDY_DLY(DLY)) dut (
    .reg_clk(clk), .reset_reg_N(rst_n), .ch_mask(ch_mask), .byteready(byteready),
    .midi_in_data(midi_in_data), .midibyte_nr(midibyte_nr), .status_ch(status_ch),
    .is_st_sysex(is_st_sysex), .syx_cmd(syx_cmd), .patch_send(patch_send),
    .auto_syx_cmd(auto_syx_cmd), .echo_rdy(echo_rdy), .cur_midi_ch(cur_midi_ch),
    .midi_bytes(midi_bytes), .seq_databyte(seq_databyte), .seq_trigger(seq_trigger),
    .data_ready(data_ready), .is_data_byte(is_data_byte), .is_velocity(is_velocity),
    .echo_valid(echo_valid), .echo_byte(echo_byte), .echo_ovf(echo_ovf)
  );

  int vectors = 0, errs = 0;

  // Reference model: expected outputs, input/trigger histories (index 0 = newest), echo queue.
  logic [3:0] e_ch;
  logic [7:0] e_mb, e_sd;
  logic       e_trig, e_drdy, e_ovf;
  bit         syx_h[16];
  bit         trig_h[16];
  logic [7:0] q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit m, pop, push;
    if (!rst_n) begin
      e_ch = 0; e_mb = 0; e_sd = 0; e_trig = 0; e_drdy = 0; e_ovf = 0;
      q.delete();
      foreach (syx_h[i]) begin syx_h[i] = 0; trig_h[i] = 0; end
      return;
    end
    m = is_st_sysex || ((int'(status_ch) < NUM_CH) && ch_mask[status_ch]);
    e_drdy = (syx_h[0] && !syx_h[1]) ||
             ((patch_send || auto_syx_cmd) && trig_h[DLY] && !trig_h[DLY+1]);
    if (ECHO) begin
      pop  = (q.size() > 0) && echo_rdy;
      push = patch_send && e_trig;
      if (pop) void'(q.pop_front());
      if (push) begin
        if (q.size() >= DEPTH) e_ovf = 1;
        else q.push_back(e_sd);
      end
    end
    e_ch   = status_ch;
    e_mb   = m ? midibyte_nr : 8'h00;
    e_sd   = m ? midi_in_data : 8'h00;
    e_trig = m && byteready;
    for (int i = 15; i > 0; i--) begin syx_h[i] = syx_h[i-1]; trig_h[i] = trig_h[i-1]; end
    syx_h[0]  = syx_cmd;
    trig_h[0] = e_trig;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    model_edge();
    chk("cur_midi_ch", cur_midi_ch, e_ch);
    chk("midi_bytes", midi_bytes, e_mb);
    chk("seq_databyte", seq_databyte, e_sd);
    chk("seq_trigger", seq_trigger, e_trig);
    chk("data_ready", data_ready, e_drdy);
    chk("is_data_byte", is_data_byte, e_mb[0]);
    chk("is_velocity", is_velocity, (!e_mb[0] && e_mb != 0));
    chk("echo_valid", echo_valid, ECHO && q.size() > 0);
    chk("echo_byte", echo_byte, (ECHO && q.size() > 0) ? q[0] : 8'h00);
    chk("echo_ovf", echo_ovf, ECHO && e_ovf);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic send(input logic [3:0] ch, input logic [7:0] d, input logic [7:0] nr);
    status_ch = ch; midi_in_data = d; midibyte_nr = nr; byteready = 1'b1;
    cyc();
    byteready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 0; byteready = 0; is_st_sysex = 0; syx_cmd = 0; patch_send = 0; auto_syx_cmd = 0;
    echo_rdy = 0; ch_mask = 4'h5; midi_in_data = 0; midibyte_nr = 0; status_ch = 0;
    e_ch = 0; e_mb = 0; e_sd = 0; e_trig = 0; e_drdy = 0; e_ovf = 0;
    cyc(); cyc();
    chk("rst_trig", seq_trigger, 0);
    chk("rst_valid", echo_valid, 0);
    rst_n = 1;

    // Channel mask 0101: ch0 and ch2 pass, ch1 rejected.
    send(4'd0, 8'h3C, 8'd1); chk("ch0_acc", seq_trigger, 1);
    send(4'd1, 8'h3D, 8'd2); chk("ch1_rej", seq_trigger, 0); chk("ch1_data0", seq_databyte, 0);
    send(4'd2, 8'h3E, 8'd1); chk("ch2_acc", seq_trigger, 1);
    idle(4);

    // Out-of-range channel only passes as SysEx.
    is_st_sysex = 1; send(4'd9, 8'h42, 8'd3); chk("syx_ch9_acc", seq_trigger, 1);
    is_st_sysex = 0; send(4'd9, 8'h42, 8'd3); chk("ch9_rej", seq_trigger, 0);
    idle(4);

    // Held syx_cmd gives one pulse two cycles after the rise.
    syx_cmd = 1;
    cyc(); chk("syx_d1", data_ready, 0);
    cyc(); chk("syx_d2", data_ready, 1);
    idle(8);
    syx_cmd = 0; idle(3);

    // Auto mode: data_ready DLY+1 cycles after each isolated trigger.
    auto_syx_cmd = 1;
    for (int k = 0; k < 3; k++) begin
      send(4'd0, 8'(8'h50 + k), 8'd1);
      idle(DLY);
      cyc(); chk("auto_drdy", data_ready, 1);
      idle(2);
    end
    auto_syx_cmd = 0; idle(2);

    // Patch echo overflow, then drain in order.
    patch_send = 1; echo_rdy = 0;
    for (int k = 0; k < 6; k++) send(4'd0, 8'(8'h11 + k), 8'd1);
    cyc();
    chk("ovf_set", echo_ovf, ECHO);
    echo_rdy = 1;
    for (int k = 0; k < 4; k++) begin
      chk("drain", echo_byte, ECHO ? 8'(8'h11 + k) : 8'h00);
      cyc();
    end
    chk("drained_empty", echo_valid, 0);
    echo_rdy = 0; idle(3);

    // Full FIFO with concurrent push and pop: no overflow, order kept.
    do_reset();
    for (int k = 0; k < 4; k++) send(4'd2, 8'(8'hA0 + k), 8'd1);
    echo_rdy = 1;
    for (int k = 4; k < 8; k++) send(4'd2, 8'(8'hA0 + k), 8'd1);
    chk("full_pp_ovf", echo_ovf, 0);
    idle(10);
    echo_rdy = 0;

    // Reset mid-burst with bytes queued and a data_ready pending.
    auto_syx_cmd = 1;
    for (int k = 0; k < 3; k++) send(4'd0, 8'(8'hC0 + k), 8'd1);
    do_reset();
    chk("rst_mid_valid", echo_valid, 0);
    chk("rst_mid_trig", seq_trigger, 0);
    idle(DLY + 3);
    chk("no_late_drdy", data_ready, 0);
    patch_send = 0; auto_syx_cmd = 0;

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      rst_n        = ($urandom_range(0, 60) != 0);
      byteready    = $urandom_range(0, 1);
      midi_in_data = 8'($urandom);
      midibyte_nr  = 8'($urandom_range(0, 4));
      status_ch    = 4'($urandom_range(0, 15));
      is_st_sysex  = ($urandom_range(0, 5) == 0);
      syx_cmd      = ($urandom_range(0, 3) == 0) ? ~syx_cmd : syx_cmd;
      if ($urandom_range(0, 20) == 0) patch_send = ~patch_send;
      if ($urandom_range(0, 20) == 0) auto_syx_cmd = ~auto_syx_cmd;
      if ($urandom_range(0, 30) == 0) ch_mask = 4'($urandom);
      echo_rdy     = ($urandom_range(0, 2) == 0);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
